// File: rtl/edid_ddc_slave_if.sv
// Host-side EDID RAM load port between the system-control register block and the DDC slave.
interface edid_ddc_slave_if;
  logic [7:0] edid_addr_i;
  logic [7:0] edid_data_i;
  logic       edid_wr_i;

  modport master (output edid_addr_i, output edid_data_i, output edid_wr_i);
  modport slave  (input  edid_addr_i, input  edid_data_i, input  edid_wr_i);
endinterface

// File: rtl/edid_ddc_slave.sv
// Monitor-side DDC/EDID EEPROM emulation: 256-byte image served read-only over an I2C slave.
// SDA is open-drain (low-drive enable only); SCL is never driven.
module edid_ddc_slave #(
  parameter logic [6:0]  g_i2c_addr   = 7'h50,
  parameter int unsigned g_glitch_len = 4
) (
  input  logic            clk_sys_i,
  input  logic            rst_n_i,
  edid_ddc_slave_if.slave edid_if,
  input  logic            scl_i,
  input  logic            sda_i,
  output logic            sda_oe_o,
  output logic            busy_o,
  output logic [7:0]      ptr_o
);

  localparam logic [3:0] c_glitch_last = 4'(g_glitch_len - 32'd1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WOFS,
    ST_WOFS_ACK,
    ST_WDISCARD,
    ST_RDATA,
    ST_RACK
  } state_t;

  // index 0 = SCL, index 1 = SDA
  logic [1:0] meta_r;
  logic [1:0] sync_r;
  logic [1:0] filt_r;
  logic [1:0] filt_d_r;
  logic [3:0] cnt_r [2];

  logic scl_rise_s;
  logic scl_fall_s;
  logic scl_high_s;
  logic start_s;
  logic stop_s;

  logic [7:0] mem_r [256];
  logic [7:0] ram_q_r;

  state_t     state_r, state_nxt_s;
  logic [3:0] bit_cnt_r, bit_cnt_nxt_s;
  logic [7:0] shift_r, shift_nxt_s;
  logic [7:0] ptr_r, ptr_nxt_s;
  logic       oe_r, oe_nxt_s;
  logic       busy_r, busy_nxt_s;
  logic       rw_r, rw_nxt_s;
  logic [7:0] shift_in_s;

  // Synchronise both pads, then let each filtered line follow only a stable level
  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      meta_r   <= 2'b11;
      sync_r   <= 2'b11;
      filt_r   <= 2'b11;
      filt_d_r <= 2'b11;
      cnt_r[0] <= 4'd0;
      cnt_r[1] <= 4'd0;
    end else begin
      meta_r   <= {sda_i, scl_i};
      sync_r   <= meta_r;
      filt_d_r <= filt_r;
      for (int i = 0; i < 2; i++) begin
        if (sync_r[i] != filt_r[i]) begin
          if (cnt_r[i] == c_glitch_last) begin
            filt_r[i] <= sync_r[i];
            cnt_r[i]  <= 4'd0;
          end else begin
            cnt_r[i]  <= cnt_r[i] + 4'd1;
          end
        end else begin
          cnt_r[i] <= 4'd0;
        end
      end
    end
  end

  // SDA edges only count as START/STOP when SCL sat high across both samples
  assign scl_rise_s = filt_r[0] & ~filt_d_r[0];
  assign scl_fall_s = ~filt_r[0] & filt_d_r[0];
  assign scl_high_s = filt_r[0] & filt_d_r[0];
  assign start_s    = scl_high_s & ~filt_r[1] & filt_d_r[1];
  assign stop_s     = scl_high_s & filt_r[1] & ~filt_d_r[1];
  assign shift_in_s = {shift_r[6:0], filt_r[1]};

  // EDID image: host write port plus registered read at the byte pointer
  always_ff @(posedge clk_sys_i) begin
    if (edid_if.edid_wr_i) begin
      mem_r[edid_if.edid_addr_i] <= edid_if.edid_data_i;
    end
    ram_q_r <= mem_r[ptr_r];
  end

  // Transaction state and datapath registers
  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r   <= ST_IDLE;
      bit_cnt_r <= 4'd0;
      shift_r   <= 8'd0;
      ptr_r     <= 8'd0;
      oe_r      <= 1'b0;
      busy_r    <= 1'b0;
      rw_r      <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      bit_cnt_r <= bit_cnt_nxt_s;
      shift_r   <= shift_nxt_s;
      ptr_r     <= ptr_nxt_s;
      oe_r      <= oe_nxt_s;
      busy_r    <= busy_nxt_s;
      rw_r      <= rw_nxt_s;
    end
  end

  // Next-state logic; bus conditions pre-empt any bit processing
  always_comb begin
    state_nxt_s   = state_r;
    bit_cnt_nxt_s = bit_cnt_r;
    shift_nxt_s   = shift_r;
    ptr_nxt_s     = ptr_r;
    oe_nxt_s      = oe_r;
    busy_nxt_s    = busy_r;
    rw_nxt_s      = rw_r;

    if (stop_s) begin
      state_nxt_s   = ST_IDLE;
      bit_cnt_nxt_s = 4'd0;
      oe_nxt_s      = 1'b0;
      busy_nxt_s    = 1'b0;
    end else if (start_s) begin
      state_nxt_s   = ST_ADDR;
      bit_cnt_nxt_s = 4'd0;
      oe_nxt_s      = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          oe_nxt_s   = 1'b0;
          busy_nxt_s = 1'b0;
        end
        ST_ADDR: begin
          if (scl_rise_s) begin
            shift_nxt_s   = shift_in_s;
            bit_cnt_nxt_s = bit_cnt_r + 4'd1;
            if (bit_cnt_r == 4'd7) begin
              bit_cnt_nxt_s = 4'd0;
              if (shift_in_s[7:1] == g_i2c_addr) begin
                state_nxt_s = ST_ADDR_ACK;
                rw_nxt_s    = shift_in_s[0];
                busy_nxt_s  = 1'b1;
              end else begin
                state_nxt_s = ST_IDLE;
                busy_nxt_s  = 1'b0;
              end
            end else begin
              state_nxt_s = ST_ADDR;
            end
          end else begin
            state_nxt_s = ST_ADDR;
          end
        end
        // oe_r doubles as the phase flag: first fall drives ACK, second fall ends it
        ST_ADDR_ACK: begin
          if (scl_fall_s) begin
            if (!oe_r) begin
              oe_nxt_s = 1'b1;
            end else if (rw_r) begin
              state_nxt_s   = ST_RDATA;
              shift_nxt_s   = ram_q_r;
              oe_nxt_s      = ~ram_q_r[7];
              bit_cnt_nxt_s = 4'd0;
            end else begin
              state_nxt_s = ST_WOFS;
              oe_nxt_s    = 1'b0;
            end
          end else begin
            state_nxt_s = ST_ADDR_ACK;
          end
        end
        ST_WOFS: begin
          if (scl_rise_s) begin
            shift_nxt_s   = shift_in_s;
            bit_cnt_nxt_s = bit_cnt_r + 4'd1;
            if (bit_cnt_r == 4'd7) begin
              bit_cnt_nxt_s = 4'd0;
              ptr_nxt_s     = shift_in_s;
              state_nxt_s   = ST_WOFS_ACK;
            end else begin
              state_nxt_s = ST_WOFS;
            end
          end else begin
            state_nxt_s = ST_WOFS;
          end
        end
        ST_WOFS_ACK: begin
          if (scl_fall_s) begin
            if (!oe_r) begin
              oe_nxt_s = 1'b1;
            end else begin
              oe_nxt_s    = 1'b0;
              state_nxt_s = ST_WDISCARD;
            end
          end else begin
            state_nxt_s = ST_WOFS_ACK;
          end
        end
        ST_WDISCARD: begin
          oe_nxt_s = 1'b0;
        end
        ST_RDATA: begin
          if (scl_rise_s) begin
            bit_cnt_nxt_s = bit_cnt_r + 4'd1;
          end else if (scl_fall_s && (bit_cnt_r != 4'd0)) begin
            if (bit_cnt_r == 4'd8) begin
              oe_nxt_s      = 1'b0;
              ptr_nxt_s     = ptr_r + 8'd1;
              bit_cnt_nxt_s = 4'd0;
              state_nxt_s   = ST_RACK;
            end else begin
              shift_nxt_s = {shift_r[6:0], 1'b0};
              oe_nxt_s    = ~shift_r[6];
            end
          end else begin
            state_nxt_s = ST_RDATA;
          end
        end
        // A fall still seen here means the master ACKed at the preceding rise
        ST_RACK: begin
          if (scl_rise_s && filt_r[1]) begin
            state_nxt_s = ST_IDLE;
            busy_nxt_s  = 1'b0;
          end else if (scl_fall_s) begin
            state_nxt_s   = ST_RDATA;
            shift_nxt_s   = ram_q_r;
            oe_nxt_s      = ~ram_q_r[7];
            bit_cnt_nxt_s = 4'd0;
          end else begin
            state_nxt_s = ST_RACK;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
          oe_nxt_s    = 1'b0;
          busy_nxt_s  = 1'b0;
        end
      endcase
    end
  end

  assign sda_oe_o = oe_r;
  assign busy_o   = busy_r;
  assign ptr_o    = ptr_r;

endmodule

// File: tb/tb_edid_ddc_slave.sv
// Scoreboarded bench for edid_ddc_slave: a bit-banged DDC master plus an EEPROM-level reference model.
module tb_edid_ddc_slave;

  localparam int G   = 4;
  localparam int H   = 125;
  localparam int Q   = 62;
  localparam int LIM = 2 + G + 1;

  logic       clk;
  logic       rst_n;
  logic       scl_m;
  logic       sda_m;
  logic       force_line;
  wire        sda_line;
  logic       sda_oe;
  logic       busy;
  logic [7:0] ptr;

  edid_ddc_slave_if edid_if ();

  edid_ddc_slave #(.g_i2c_addr(7'h50), .g_glitch_len(G)) dut (
    .clk_sys_i (clk),
    .rst_n_i   (rst_n),
    .edid_if   (edid_if),
    .scl_i     (scl_m),
    .sda_i     (sda_line),
    .sda_oe_o  (sda_oe),
    .busy_o    (busy),
    .ptr_o     (ptr)
  );

  // Wired-AND open-drain line; force_line lets the master override a driving slave
  assign sda_line = force_line ? sda_m : (sda_m & ~sda_oe);

  initial clk = 1'b0;
  always #20 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: an EEPROM with a byte pointer
  logic [7:0] ref_mem [256];
  logic [7:0] ref_ptr = 8'd0;
  logic       ref_sel = 1'b0;
  logic       ref_rd  = 1'b0;
  int         ref_wcnt = 0;

  logic [7:0] exp_q [$];
  string      name_q [$];

  event       sample_ev;
  int         mon_kind = 0;
  logic       watch_oe = 1'b0;
  logic       oe_seen  = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  task automatic pop_cmp(input logic [7:0] got);
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_underflow: got=0x%0h expected=none", got);
    end else begin
      check(name_q.pop_front(), {24'd0, got}, {24'd0, exp_q.pop_front()});
    end
  endtask

  // Monitor: ack slots (kind 1) and read data bits (kind 2) sampled mid SCL-high
  initial begin
    logic [7:0] rd_sh;
    int         rd_n;
    rd_sh = 8'd0;
    rd_n  = 0;
    forever begin
      @(sample_ev);
      if (mon_kind == 1) begin
        pop_cmp({7'd0, sda_line});
      end else begin
        rd_sh = {rd_sh[6:0], sda_line};
        rd_n++;
        if (rd_n == 8) begin
          rd_n = 0;
          pop_cmp(rd_sh);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (watch_oe && sda_oe) oe_seen <= 1'b1;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic host_wr(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    edid_if.edid_addr_i = a;
    edid_if.edid_data_i = d;
    edid_if.edid_wr_i   = 1'b1;
    @(negedge clk);
    edid_if.edid_wr_i   = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic bit_cycle(input logic b, input int kind);
    wait_clk(Q);
    sda_m = b;
    wait_clk(H - Q);
    scl_m = 1'b1;
    wait_clk(Q);
    if (kind != 0) begin
      mon_kind = kind;
      -> sample_ev;
    end
    wait_clk(H - Q);
    scl_m = 1'b0;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1;
    wait_clk(Q);
    scl_m = 1'b1;
    wait_clk(H);
    sda_m = 1'b0;
    wait_clk(H);
    scl_m = 1'b0;
  endtask

  task automatic i2c_stop();
    wait_clk(Q);
    sda_m = 1'b0;
    wait_clk(H - Q);
    scl_m = 1'b1;
    wait_clk(H);
    sda_m = 1'b1;
    wait_clk(H);
    ref_sel = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) bit_cycle(b[i], 0);
    bit_cycle(1'b1, 1);
  endtask

  task automatic tx_addr(input logic [7:0] b);
    ref_sel  = (b[7:1] == 7'h50);
    ref_rd   = b[0];
    ref_wcnt = 0;
    exp_q.push_back(ref_sel ? 8'd0 : 8'd1);
    name_q.push_back($sformatf("addr_ack_%02h", b));
    send_byte(b);
  endtask

  task automatic tx_wr(input logic [7:0] b);
    if (ref_sel && !ref_rd && ref_wcnt == 0) begin
      ref_ptr = b;
      exp_q.push_back(8'd0);
    end else begin
      exp_q.push_back(8'd1);
    end
    name_q.push_back($sformatf("wr_ack_%02h_n%0d", b, ref_wcnt));
    ref_wcnt++;
    send_byte(b);
  endtask

  task automatic read_byte(input logic nack, input logic mid_wr,
                           input logic [7:0] a1, input logic [7:0] d1,
                           input logic [7:0] a2, input logic [7:0] d2);
    exp_q.push_back(ref_mem[ref_ptr]);
    name_q.push_back($sformatf("rd_byte_%02h", ref_ptr));
    ref_ptr = ref_ptr + 8'd1;
    for (int i = 0; i < 8; i++) begin
      bit_cycle(1'b1, 2);
      if (mid_wr && i == 3) begin
        host_wr(a1, d1);
        host_wr(a2, d2);
      end
    end
    bit_cycle(nack, 0);
    if (nack) ref_sel = 1'b0;
  endtask

  initial begin
    logic [7:0] o, o1, rv0, rv1, rv2;
    int n;
    rst_n = 1'b0;
    scl_m = 1'b1;
    sda_m = 1'b1;
    force_line = 1'b0;
    edid_if.edid_addr_i = 8'd0;
    edid_if.edid_data_i = 8'd0;
    edid_if.edid_wr_i   = 1'b0;
    wait_clk(5);
    check("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ptr", {24'd0, ptr}, 32'd0);
    rst_n = 1'b1;
    wait_clk(10);

    for (int i = 0; i < 256; i++) host_wr(8'(i), 8'(i) ^ 8'hA5);

    // offset write, repeated start, four-byte read
    i2c_start();
    tx_addr(8'hA0);
    tx_wr(8'h10);
    check("busy_mid_txn", {31'd0, busy}, {31'd0, ref_sel});
    i2c_start();
    tx_addr(8'hA1);
    read_byte(1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
    read_byte(1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
    read_byte(1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
    read_byte(1'b1, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
    i2c_stop();
    check("ptr_after_read4", {24'd0, ptr}, {24'd0, ref_ptr});
    check("busy_after_stop", {31'd0, busy}, 32'd0);

    // foreign address
    i2c_start();
    oe_seen  = 1'b0;
    watch_oe = 1'b1;
    tx_addr(8'hA2);
    tx_wr(8'h00);
    watch_oe = 1'b0;
    i2c_stop();
    check("foreign_no_drive", {31'd0, oe_seen}, 32'd0);
    check("foreign_busy", {31'd0, busy}, 32'd0);
    check("foreign_ptr", {24'd0, ptr}, {24'd0, ref_ptr});

    // pointer wrap
    i2c_start();
    tx_addr(8'hA0);
    tx_wr(8'hFE);
    i2c_start();
    tx_addr(8'hA1);
    read_byte(1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
    read_byte(1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
    read_byte(1'b1, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
    i2c_stop();
    check("ptr_wrap", {24'd0, ptr}, {24'd0, ref_ptr});

    // DDC data writes are refused
    i2c_start();
    tx_addr(8'hA0);
    tx_wr(8'h20);
    tx_wr(8'h55);
    i2c_stop();
    check("ptr_after_wr", {24'd0, ptr}, {24'd0, ref_ptr});
    i2c_start();
    tx_addr(8'hA1);
    read_byte(1'b1, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
    i2c_stop();
    check("ptr_after_readback", {24'd0, ptr}, {24'd0, ref_ptr});

    // short SDA glitch with SCL high must not start a transaction
    wait_clk(20);
    sda_m = 1'b0;
    wait_clk(G - 1);
    sda_m = 1'b1;
    wait_clk(30);
    check("glitch_busy", {31'd0, busy}, 32'd0);
    scl_m = 1'b0;
    tx_wr(8'hA0);
    i2c_stop();

    // STOP forced while the slave drives a 0 data bit
    i2c_start();
    tx_addr(8'hA1);
    bit_cycle(1'b1, 0);
    wait_clk(20);
    check("drive_bit6_low", {31'd0, sda_oe}, 32'd1);
    force_line = 1'b1;
    sda_m = 1'b0;
    wait_clk(Q);
    scl_m = 1'b1;
    wait_clk(H);
    check("hold_under_scl_high", {31'd0, sda_oe}, 32'd1);
    sda_m = 1'b1;
    n = 0;
    while (n < 40 && sda_oe) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (sda_oe || n > LIM) begin
      bad++;
      $display("FAIL stop_release_latency: got=%0d cycles (oe=%0b) limit=%0d", n, sda_oe, LIM);
    end
    wait_clk(H);
    force_line = 1'b0;
    ref_sel = 1'b0;
    check("stop_mid_busy", {31'd0, busy}, 32'd0);
    check("stop_mid_ptr", {24'd0, ptr}, {24'd0, ref_ptr});

    // asynchronous reset while driving a 0 bit
    i2c_start();
    tx_addr(8'hA1);
    bit_cycle(1'b1, 0);
    wait_clk(20);
    check("pre_reset_drive", {31'd0, sda_oe}, 32'd1);
    #7 rst_n = 1'b0;
    #1 check("async_reset_release", {31'd0, sda_oe}, 32'd0);
    wait_clk(3);
    rst_n = 1'b1;
    ref_ptr = 8'd0;
    ref_sel = 1'b0;
    check("post_reset_ptr", {24'd0, ptr}, 32'd0);
    check("post_reset_busy", {31'd0, busy}, 32'd0);
    i2c_start();
    tx_addr(8'hA1);
    read_byte(1'b1, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
    i2c_stop();
    check("post_reset_read_ptr", {24'd0, ptr}, {24'd0, ref_ptr});

    // random offset, with host writes landing mid-byte
    o   = 8'($urandom_range(0, 255));
    o1  = o + 8'd1;
    rv0 = 8'($urandom);
    rv1 = 8'($urandom);
    rv2 = 8'($urandom);
    host_wr(o, rv0);
    i2c_start();
    tx_addr(8'hA0);
    tx_wr(o);
    i2c_start();
    tx_addr(8'hA1);
    read_byte(1'b0, 1'b1, o, rv1, o1, rv2);
    read_byte(1'b1, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
    i2c_stop();
    check("rand_ptr", {24'd0, ptr}, {24'd0, ref_ptr});

    wait_clk(10);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/edid_ddc_slave.md
Name: edid_ddc_slave

Overview:
- Emulates the monitor-side DDC/EDID EEPROM. Holds a 256-byte EDID image and serves it over an I2C slave interface at address 0x50.
- The image is loaded by the system-control register block through its EDID control write strobe (address byte, data byte, single-cycle write pulse).
- The block sits directly downstream of the system-control register block.
- It connects to the board DDC pins through an open-drain pad (low-drive enable only).

Parameters:
g_i2c_addr, 7'h50, 7-bit slave address answered on DDC
g_glitch_len, 4, clk_sys_i cycles a synchronised SCL/SDA level must be stable before the filtered line follows it (range 1..15)

Ports:
clk_sys_i  input  1  system clock
rst_n_i  input  1  reset; asynchronous, active-low
edid_addr_i  input  8  EDID RAM write address from register block
edid_data_i  input  8  EDID RAM write data
edid_wr_i  input  1  single-cycle write strobe; writes edid_data_i to edid_addr_i
scl_i  input  1  DDC SCL pad input (asynchronous)
sda_i  input  1  DDC SDA pad input (asynchronous)
sda_oe_o  input/output n/a: output  1  1 = pull SDA low; 0 = release
busy_o  output  1  1 while a transaction addressed to this slave is in progress
ptr_o  output  8  current EDID byte pointer (debug/status)

Behaviour:
- Reset (async, rst_n_i low): sda_oe_o=0, busy_o=0, ptr_o=0, state IDLE, filters preset to 1. RAM contents are not reset.
- Reset asserted mid-transaction releases SDA immediately (async clear).
- RAM: 256x8, one write port (host), one read port addressed by ptr, 1-cycle read latency. edid_wr_i is accepted in every state.
- A host write to the byte currently held in the shift register does not alter that byte. The new value appears on the next load.
- Input conditioning:
  - 2-FF synchroniser on each line.
  - Stability filter: the filtered line changes only after g_glitch_len consecutive equal synchronised samples.
  - Edge detect on the filtered lines.
  - Total input latency is 2+g_glitch_len cycles.
- Bus conditions, checked on filtered lines, evaluated every cycle, taking priority over bit processing:
  - START = SDA fall while SCL high.
  - STOP = SDA rise while SCL high.
- Bits are sampled on SCL rising edges. sda_oe_o changes only on SCL falling edges (+1 cycle).
- State machine:
  - IDLE: on START -> ADDR, bit count 0.
  - ADDR: shift 8 bits MSB first.
    - If bits[7:1]==g_i2c_addr -> ADDR_ACK, sda_oe_o=1 from the following SCL fall. busy_o=1 from this point.
    - Otherwise -> IDLE, no ACK.
  - ADDR_ACK: release on the next SCL fall.
    - R/W=0 -> WOFS.
    - R/W=1 -> RDATA, loading shift register from RAM[ptr].
  - WOFS: shift 8 bits into ptr (ptr updated at 8th SCL rise) -> WOFS_ACK (ACK driven as for the address).
  - WOFS_ACK -> WDISCARD.
  - WDISCARD: further written bytes are NACKed (SDA released) and ignored. The RAM is read-only over DDC; ptr is unchanged.
  - RDATA:
    - sda_oe_o = ~shift[7] from each SCL fall; shift left on each SCL fall after a sample.
    - After the 8th bit, release SDA, ptr <= ptr+1 (8-bit wrap 255->0) -> RACK.
  - RACK: sample SDA at the SCL rise.
    - 0 (ACK) -> load RAM[ptr] at the SCL fall -> RDATA.
    - 1 (NACK) -> IDLE; SDA stays released.
- STOP in any state: -> IDLE, sda_oe_o=0 within 1 cycle, busy_o=0, ptr retained.
- Repeated START in any state: -> ADDR, sda_oe_o=0, ptr retained. This is the standard EDID "write offset, Sr, read" sequence.
- START and STOP are impossible in the same cycle (single SDA edge). SCL and SDA edges in the same filtered cycle are treated as a data bit, not START/STOP.
- Clock stretching is not supported; SCL is never driven.

Test Plan:
- Use clk_sys_i = 25 MHz and SCL at 100 kHz (125 clk per half period).
- Host-load RAM[i]=i^8'hA5 for all i. DDC: START, 0xA0, 0x10, Sr, 0xA1, read 4 bytes with ACK,ACK,ACK,NACK, STOP.
  - Required: ACKs on the address/offset/address phases; data 0xB5,0xB4,0xB7,0xB6; ptr_o=0x14 after; busy_o=0 after STOP.
- Address 0xA2 (0x51) -> no ACK (sda_oe_o stays 0 for the entire transfer), busy_o stays 0, ptr_o unchanged.
- Offset 0xFE, then read 3 bytes -> RAM[0xFE], RAM[0xFF], RAM[0x00]; ptr_o=0x01 (wrap).
- Write sequence 0xA0, 0x20, 0x55 -> ACK, ACK, NACK. RAM[0x20] unchanged on readback; ptr_o=0x20.
- SDA glitch of g_glitch_len-1 cycles while SCL high during idle -> no START detected, busy_o=0. STOP issued mid-read-byte -> sda_oe_o=0 within 2+g_glitch_len+1 cycles.
- Assert rst_n_i while slave drives a 0 data bit -> sda_oe_o falls asynchronously. After release, the next read starts at ptr=0.
